// File: rtl/gesture_pkg.sv
// Shared types and constants for the gesture sequencer: FSM states,
// detector symbol encodings and default sizing.
package gesture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    typedef logic [1:0] sym_t;

    localparam sym_t SYM_IDLE   = 2'b00;
    localparam sym_t SYM_CLEAR  = 2'b01;
    localparam sym_t SYM_TOGGLE = 2'b10;
    localparam sym_t SYM_SET    = 2'b11;

    localparam int DEF_MAXLEN = 8;
    localparam int DEF_LENW   = 4;
    localparam int DEF_GAP    = 3;

    // Requester index of a one-hot two-bit grant.
    function automatic logic gnt_idx(input logic [1:0] gnt);
        return gnt[1];
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: grants req[ptr] if set, else the other
// requester; on advance the pointer moves to the requester not granted.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant = 2'b00;
        ptr_d = ptr_q;
        if (req[ptr_q]) begin
            grant = ptr_q ? 2'b10 : 2'b01;
        end else if (req != 2'b00) begin
            // Only the non-favoured requester is asking.
            grant = req;
        end
        if (advance && (grant != 2'b00)) begin
            ptr_d = ~grant[1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/gesture_sequencer.sv
// Shares one gesture detector between two requesters: plays a granted
// sequence onto ain, appends idle symbols, then returns the detector output.
module gesture_sequencer
    import gesture_pkg::*;
#(
    parameter int MAXLEN = DEF_MAXLEN,
    parameter int LENW   = DEF_LENW,
    parameter int GAP    = DEF_GAP
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req,
    input  logic [2*MAXLEN-1:0] seq0,
    input  logic [LENW-1:0]     len0,
    input  logic [2*MAXLEN-1:0] seq1,
    input  logic [LENW-1:0]     len1,
    output logic [1:0]          gnt,
    output logic [1:0]          done,
    output logic                result,
    output logic                busy,
    output logic [1:0]          ain,
    input  logic                det_yout
);

    localparam int SEQW = 2 * MAXLEN;
    localparam int GAPW = $clog2(GAP + 1);
    localparam logic [LENW-1:0] LEN_MAX  = LENW'(MAXLEN);
    localparam logic [GAPW-1:0] GAP_LAST = GAPW'(GAP);

    state_e          state_q, state_d;
    logic [SEQW-1:0] seq_q, seq_d;
    logic [LENW-1:0] len_q, len_d;
    logic [LENW-1:0] idx_q, idx_d;
    logic [GAPW-1:0] gap_q, gap_d;
    logic            owner_q, owner_d;
    logic [1:0]      gnt_q, gnt_d;
    logic [1:0]      done_q, done_d;
    logic            result_q, result_d;
    logic            busy_q, busy_d;
    sym_t            ain_q, ain_d;

    logic [1:0]      arb_gnt;
    logic            arb_advance;
    logic [SEQW-1:0] sel_seq;
    logic [LENW-1:0] sel_len_raw;
    logic [LENW-1:0] sel_len;

    assign arb_advance = (state_q == ST_IDLE);

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (arb_advance),
        .grant   (arb_gnt)
    );

    always_comb begin
        sel_seq     = gnt_idx(arb_gnt) ? seq1 : seq0;
        sel_len_raw = gnt_idx(arb_gnt) ? len1 : len0;
        sel_len     = (sel_len_raw > LEN_MAX) ? LEN_MAX : sel_len_raw;
    end

    // NOTE: every _d gets a default before the case so no path leaves a
    // combinational output unassigned, which would infer a latch.
    always_comb begin
        state_d  = state_q;
        seq_d    = seq_q;
        len_d    = len_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        owner_d  = owner_q;
        result_d = result_q;
        busy_d   = busy_q;
        gnt_d    = 2'b00;
        done_d   = 2'b00;
        ain_d    = SYM_IDLE;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_gnt != 2'b00) begin
                    gnt_d   = arb_gnt;
                    owner_d = gnt_idx(arb_gnt);
                    busy_d  = 1'b1;
                    len_d   = sel_len;
                    if (sel_len == '0) begin
                        seq_d   = sel_seq;
                        gap_d   = GAPW'(1);
                        state_d = ST_GAP;
                    end else begin
                        // Symbol 0 goes out now; the shifter holds the rest.
                        ain_d   = sel_seq[1:0];
                        seq_d   = sel_seq >> 2;
                        idx_d   = LENW'(1);
                        state_d = ST_PLAY;
                    end
                end
            end
            ST_PLAY: begin
                if (idx_q == len_q) begin
                    gap_d   = GAPW'(1);
                    state_d = ST_GAP;
                end else begin
                    ain_d = seq_q[1:0];
                    seq_d = seq_q >> 2;
                    idx_d = idx_q + LENW'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    result_d = det_yout;
                    done_d   = owner_q ? 2'b10 : 2'b01;
                    state_d  = ST_RESP;
                end else begin
                    gap_d = gap_q + GAPW'(1);
                end
            end
            ST_RESP: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            seq_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            gap_q    <= '0;
            owner_q  <= 1'b0;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            result_q <= 1'b0;
            busy_q   <= 1'b0;
            ain_q    <= SYM_IDLE;
        end else begin
            state_q  <= state_d;
            seq_q    <= seq_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            owner_q  <= owner_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            ain_q    <= ain_d;
        end
    end

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign result = result_q;
    assign busy   = busy_q;
    assign ain    = ain_q;

endmodule
